// File: rtl/arb_pkg.sv
// Shared constants for the 16-way round-robin arbiter.
package arb_pkg;

   localparam int N   = 16;
   localparam int IDW = 4;

   // Arbiter FSM encoding
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Rotating priority picker: returns the first set request at or after
// last_ptr+1 (wrapping), using rotate / fixed-priority encode / re-offset.
module rr_pick
   import arb_pkg::*;
(
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] last_ptr_i,
   output logic [IDW-1:0] winner_o,
   output logic           any_o
);

   logic [IDW-1:0] start;
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IDW-1:0] off;

   // Rotate so the search start lands on bit 0, find the lowest set bit,
   // then add the start back; IDW-bit arithmetic gives the mod-16 wrap.
   always_comb begin
      start = last_ptr_i + 1'b1;
      dbl   = {req_i, req_i} >> start;
      rot   = dbl[N-1:0];
      off   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) off = IDW'(k);
      end
      winner_o = start + off;
      any_o    = |req_i;
   end

endmodule : rr_pick

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter with registered one-hot + binary grant,
// owner release, and an optional hold timeout that demotes the offender.
//
// Handshake: a requester holds req high; the cycle after it is sampled in
// IDLE, gnt/gnt_id/gnt_valid present the winner. The grant stays until the
// owner pulses release or drops its req, or the hold timeout fires; one idle
// cycle always follows before the next grant.
module rr_arbiter_16
   import arb_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic [N-1:0]   req_i,
   input  logic           release_i,
   output logic [N-1:0]   gnt_o,
   output logic [IDW-1:0] gnt_id_o,
   output logic           gnt_valid_o,
   output logic           timeout_o,
   output logic [0:0]     dbg_state_o
);

   localparam logic [N-1:0]  ONE_HOT0 = N'(1);
   localparam bit            TO_EN    = (TIMEOUT != 0);
   localparam logic [CW-1:0] TO_LAST  = CW'(TO_EN ? TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   logic [0:0]     state_q,    state_d;
   logic [IDW-1:0] last_ptr_q, last_ptr_d;
   logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
   logic [N-1:0]   gnt_q,      gnt_d;
   logic [IDW-1:0] gnt_id_q,   gnt_id_d;
   logic           timeout_q,  timeout_d;

   logic [IDW-1:0] winner;
   logic           any_req;

   rr_pick u_pick (
      .req_i      (req_i),
      .last_ptr_i (last_ptr_q),
      .winner_o   (winner),
      .any_o      (any_req)
   );

   // Next-state: grant from IDLE, release/drop/timeout back to IDLE.
   always_comb begin
      state_d    = state_q;
      last_ptr_d = last_ptr_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      gnt_id_d   = gnt_id_q;
      timeout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d    = ST_GRANT;
               gnt_d      = ONE_HOT0 << winner;
               gnt_id_d   = winner;
               last_ptr_d = winner;
               hold_cnt_d = '0;
            end
         end
         default: begin
            if (release_i || !req_i[gnt_id_q]) begin
               state_d  = ST_IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
            end else if (TO_EN && (hold_cnt_q == TO_LAST)) begin
               // last_ptr keeps the revoked index: offender drops to lowest priority
               state_d   = ST_IDLE;
               gnt_d     = '0;
               gnt_id_d  = '0;
               timeout_d = 1'b1;
            end else if (hold_cnt_q != CNT_MAX) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // State and output registers; reset overrides a grant in progress.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         last_ptr_q <= IDW'(N - 1);
         hold_cnt_q <= '0;
         gnt_q      <= '0;
         gnt_id_q   <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_ptr_q <= last_ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         timeout_q  <= timeout_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_id_o    = gnt_id_q;
   assign gnt_valid_o = (state_q == ST_GRANT);
   assign timeout_o   = timeout_q;
   assign dbg_state_o = state_q;

endmodule : rr_arbiter_16

// File: tb/tb_rr_arbiter_16.sv
// Bench for rr_arbiter_16 (TIMEOUT=4) and its rr_pick picker.
module tb_rr_arbiter_16;

   localparam int TO = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic [15:0] req   = '0;
   logic        rel   = 1'b0;

   logic [15:0] gnt;
   logic [3:0]  gnt_id;
   logic        gnt_valid;
   logic        timeout;
   logic [0:0]  dbg_state;

   rr_arbiter_16 #(.TIMEOUT(TO), .CW(8)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_i       (req),
      .release_i   (rel),
      .gnt_o       (gnt),
      .gnt_id_o    (gnt_id),
      .gnt_valid_o (gnt_valid),
      .timeout_o   (timeout),
      .dbg_state_o (dbg_state)
   );

   // standalone picker
   logic [15:0] p_req;
   logic [3:0]  p_last;
   logic [3:0]  p_win;
   logic        p_any;

   rr_pick u_pick_chk (
      .req_i      (p_req),
      .last_ptr_i (p_last),
      .winner_o   (p_win),
      .any_o      (p_any)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // expected {timeout, gnt_valid, gnt_id, gnt}
   logic [21:0] exp_q[$];

   // ---------------- reference model ----------------
   // owner = -1 when idle; last = most recently granted index
   int m_owner = -1;
   int m_last  = 15;
   int m_hold  = 0;
   bit m_tflag = 1'b0;

   task automatic model_step(input logic [15:0] r, input logic rl, input logic rst);
      if (rst) begin
         m_owner = -1; m_last = 15; m_hold = 0; m_tflag = 1'b0;
      end else if (m_owner < 0) begin
         m_tflag = 1'b0;
         for (int i = 1; i <= 16; i++) begin
            int idx;
            idx = (m_last + i) % 16;
            if (r[idx]) begin
               m_owner = idx; m_last = idx; m_hold = 0;
               break;
            end
         end
      end else begin
         m_tflag = 1'b0;
         if (rl || !r[m_owner]) begin
            m_owner = -1;
         end else if (TO != 0 && m_hold == TO - 1) begin
            m_owner = -1;
            m_tflag = 1'b1;
         end else if (m_hold < 255) begin
            m_hold = m_hold + 1;
         end
      end
   endtask

   function automatic logic [21:0] model_out();
      logic [15:0] g;
      logic [3:0]  id;
      g  = '0;
      id = '0;
      if (m_owner >= 0) begin
         g  = 16'h0001 << m_owner;
         id = 4'(m_owner);
      end
      return {m_tflag, (m_owner >= 0), id, g};
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input logic [15:0] r, input logic rl, input logic rst);
      @(negedge clk);
      req   = r;
      rel   = rl;
      reset = rst;
      model_step(r, rl, rst);
      exp_q.push_back(model_out());
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) begin
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         logic [21:0] e, a;
         e = exp_q.pop_front();
         a = {timeout, gnt_valid, gnt_id, gnt};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs cyc=%0d got t=%0b v=%0b id=%0d gnt=%h exp t=%0b v=%0b id=%0d gnt=%h",
                     cyc, a[21], a[20], a[19:16], a[15:0], e[21], e[20], e[19:16], e[15:0]);
         end
      end
   end

   // ---------------- picker reference check ----------------
   task automatic pick_check(input logic [15:0] r, input logic [3:0] lp);
      int exp_w;
      p_req  = r;
      p_last = lp;
      #1;
      exp_w = -1;
      for (int i = 1; i <= 16; i++) begin
         if (exp_w < 0 && r[(int'(lp) + i) % 16]) exp_w = (int'(lp) + i) % 16;
      end
      checks++;
      if (p_any !== (r != 16'h0) || (exp_w >= 0 && p_win !== 4'(exp_w))) begin
         errors++;
         $display("FAIL pick req=%h last=%0d got any=%0b win=%0d exp any=%0b win=%0d",
                  r, lp, p_any, p_win, (r != 16'h0), exp_w);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] r;
      p_req  = '0;
      p_last = '0;

      // picker: corners then random
      pick_check(16'h0000, 4'd3);
      pick_check(16'h0001, 4'd15);
      pick_check(16'h8000, 4'd15);
      pick_check(16'h0021, 4'd5);
      pick_check(16'hFFFF, 4'd14);
      for (int i = 0; i < 200; i++)
         pick_check(16'($urandom) & 16'($urandom), 4'($urandom_range(0, 15)));

      // reset state
      drive(16'h0000, 1'b0, 1'b1);
      drive(16'hFFFF, 1'b0, 1'b1);

      // plan 1: single requester, release
      drive(16'h0001, 1'b0, 1'b0);
      drive(16'h0001, 1'b1, 1'b0);
      drive(16'h0000, 1'b0, 1'b0);
      drive(16'h0000, 1'b1, 1'b0);   // release while idle

      // plan 2: all requesting, release every grant -> 0..15,0
      drive(16'h0000, 1'b0, 1'b1);
      for (int i = 0; i < 17; i++) begin
         drive(16'hFFFF, 1'b0, 1'b0);
         drive(16'hFFFF, 1'b1, 1'b0);
      end

      // plan 3: last_ptr=5, req bits 0 and 5 -> 0, then 5
      drive(16'h0000, 1'b0, 1'b1);
      drive(16'h0020, 1'b0, 1'b0);
      drive(16'h0020, 1'b1, 1'b0);
      drive(16'h0021, 1'b0, 1'b0);
      drive(16'h0021, 1'b1, 1'b0);
      drive(16'h0020, 1'b0, 1'b0);
      drive(16'h0020, 1'b1, 1'b0);

      // plan 4: timeout on held req, regrant after idle cycle
      drive(16'h0000, 1'b0, 1'b1);
      for (int i = 0; i < 13; i++) drive(16'h0100, 1'b0, 1'b0);

      // release coinciding with the timeout cycle
      drive(16'h0000, 1'b0, 1'b1);
      drive(16'h0100, 1'b0, 1'b0);
      drive(16'h0100, 1'b0, 1'b0);
      drive(16'h0100, 1'b0, 1'b0);
      drive(16'h0100, 1'b0, 1'b0);
      drive(16'h0100, 1'b1, 1'b0);
      drive(16'h0000, 1'b0, 1'b0);

      // timeout demotes the offender while another waits
      drive(16'h0000, 1'b0, 1'b1);
      drive(16'h0002, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) drive(16'h0006, 1'b0, 1'b0);

      // plan 5: owner 3 drops, 9 waiting
      drive(16'h0000, 1'b0, 1'b1);
      drive(16'h0008, 1'b0, 1'b0);
      drive(16'h0208, 1'b0, 1'b0);
      drive(16'h0200, 1'b0, 1'b0);
      drive(16'h0200, 1'b0, 1'b0);
      drive(16'h0200, 1'b1, 1'b0);

      // plan 6: reset during grant on 12, then 0 wins
      drive(16'h0000, 1'b0, 1'b1);
      drive(16'h1000, 1'b0, 1'b0);
      drive(16'h1000, 1'b0, 1'b0);
      drive(16'h1001, 1'b0, 1'b1);
      drive(16'h1001, 1'b0, 1'b0);
      drive(16'h1001, 1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       r = 16'h0;
            1:       r = 16'h0001 << $urandom_range(0, 15);
            default: r = 16'($urandom) & 16'($urandom);
         endcase
         drive(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
         // sometimes hold the request steady to reach the timeout
         if ($urandom_range(0, 9) == 0) begin
            for (int k = 0; k < 6; k++) drive(r, 1'b0, 1'b0);
         end
      end

      // drain: every expected entry must have been consumed
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending entries, exp 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_rr_arbiter_16
